// File: rtl/spi_shift_engine_if.sv
// Parallel load/result and serial-pin bundle for spi_shift_engine.
// The engine takes the slave side; the bench or upstream logic takes master.
interface spi_shift_engine_if #(
   parameter int WIDTH = 8
);
   logic             sclk_pos_edge;
   logic             sclk_neg_edge;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             miso;
   logic             mosi;
   logic             cs_n;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             busy;

   modport master (
      output sclk_pos_edge, sclk_neg_edge, tx_data, tx_valid, miso,
      input  tx_ready, mosi, cs_n, rx_data, rx_valid, busy
   );

   modport slave (
      input  sclk_pos_edge, sclk_neg_edge, tx_data, tx_valid, miso,
      output tx_ready, mosi, cs_n, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_shift_engine.sv
// Full-duplex WIDTH-bit SPI shift stage driven by sclk edge strobes, MSB first.
// Define SPI_SHIFT_BURST_EN to chain frames under one cs_n assertion.
module spi_shift_engine #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_shift_engine_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic             seen_pos_r, seen_pos_s;
   // mosi is the MSB of the tx shift register, so it is a flop by construction
   logic [WIDTH-1:0] tx_sh_r, tx_sh_s;
   logic [WIDTH-2:0] rx_sh_r, rx_sh_s;
   logic [WIDTH-1:0] rx_data_r, rx_data_s;
   logic [WIDTH-1:0] rx_next_s;
   logic             rx_valid_r, rx_valid_s;
   logic             cs_n_r, cs_n_s;
   logic             busy_r;
   logic             tx_ready_s;
   logic             load_s;

   // Load acceptance decoded from state (and the neg strobe in burst mode)
   always_comb begin
      tx_ready_s = 1'b0;
      case (state_r)
         IDLE: tx_ready_s = 1'b1;
         HOLD: begin
`ifdef SPI_SHIFT_BURST_EN
            tx_ready_s = bus.sclk_neg_edge;
`else
            tx_ready_s = 1'b0;
`endif
         end
         default: tx_ready_s = 1'b0;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      seen_pos_s = seen_pos_r;
      tx_sh_s    = tx_sh_r;
      rx_sh_s    = rx_sh_r;
      rx_data_s  = rx_data_r;
      rx_valid_s = 1'b0;
      cs_n_s     = cs_n_r;
      load_s     = bus.tx_valid && tx_ready_s;
      rx_next_s  = {rx_sh_r, bus.miso};
      case (state_r)
         IDLE: begin
            if (load_s) begin
               state_s    = SHIFT;
               tx_sh_s    = bus.tx_data;
               cs_n_s     = 1'b0;
               cnt_s      = '0;
               seen_pos_s = 1'b0;
               rx_sh_s    = '0;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            // A rising strobe wins over a coincident falling strobe
            if (bus.sclk_pos_edge) begin
               rx_sh_s    = rx_next_s[WIDTH-2:0];
               seen_pos_s = 1'b1;
               if (cnt_r != CW'(WIDTH)) begin
                  cnt_s = cnt_r + CW'(1);
               end else begin
                  cnt_s = cnt_r;
               end
               if (cnt_s == CW'(WIDTH)) begin
                  rx_data_s  = rx_next_s;
                  rx_valid_s = 1'b1;
                  state_s    = HOLD;
               end else begin
                  state_s = SHIFT;
               end
            end else if (bus.sclk_neg_edge && seen_pos_r && (cnt_r < CW'(WIDTH))) begin
               tx_sh_s = {tx_sh_r[WIDTH-2:0], 1'b0};
            end else begin
               state_s = SHIFT;
            end
         end
         HOLD: begin
            if (bus.sclk_neg_edge) begin
               if (load_s) begin
                  state_s    = SHIFT;
                  tx_sh_s    = bus.tx_data;
                  cnt_s      = '0;
                  seen_pos_s = 1'b0;
                  rx_sh_s    = '0;
               end else begin
                  state_s = IDLE;
                  cs_n_s  = 1'b1;
                  tx_sh_s = '0;
               end
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
            cs_n_s  = 1'b1;
            tx_sh_s = '0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         seen_pos_r <= 1'b0;
         tx_sh_r    <= '0;
         rx_sh_r    <= '0;
         rx_data_r  <= '0;
         rx_valid_r <= 1'b0;
         cs_n_r     <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         seen_pos_r <= seen_pos_s;
         tx_sh_r    <= tx_sh_s;
         rx_sh_r    <= rx_sh_s;
         rx_data_r  <= rx_data_s;
         rx_valid_r <= rx_valid_s;
         cs_n_r     <= cs_n_s;
         busy_r     <= (state_s != IDLE);
      end
   end

   assign bus.tx_ready = tx_ready_s;
   assign bus.mosi     = tx_sh_r[WIDTH-1];
   assign bus.cs_n     = cs_n_r;
   assign bus.rx_data  = rx_data_r;
   assign bus.rx_valid = rx_valid_r;
   assign bus.busy     = busy_r;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: free-running sclk strobe source,
// bit-level slave model and a monitor that rebuilds the serial streams.
module tb_spi_shift_engine;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_shift_engine_if #(.WIDTH(WIDTH)) bus ();
   spi_shift_engine #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;

   // sclk source: 8 clk period, rising strobe at phase 0, falling at phase 4
   int          phase = 7;
   logic [15:0] slave_q = 16'h0000;
   int          slave_base = 0;
   bit          slave_en = 1'b0;
   logic        rnd_miso = 1'b0;

   // monitor state
   int         n_rise = 0;
   bit         mosi_bits[$];
   logic [7:0] rx_words[$];
   logic [7:0] acc[$];
   bit         acc_cs[$];
   int         cs_rises = 0;
   int         rise_at_cs = 0;
   bit         neg_before = 1'b0;
   bit         prev_cs = 1'b1;
   bit         prev_neg = 1'b0;

   int b_rise, b_mosi, b_rx, b_cs, b_acc;

   initial begin
      bus.sclk_pos_edge = 1'b0;
      bus.sclk_neg_edge = 1'b0;
      bus.miso = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         phase = (phase + 1) % 8;
         bus.sclk_pos_edge = (phase == 0);
         bus.sclk_neg_edge = (phase == 4);
         if (!slave_en)
            bus.miso = rnd_miso;
         else if (bus.sclk_neg_edge || (n_rise == slave_base))
            bus.miso = ((n_rise - slave_base) < 16) ? slave_q[15 - (n_rise - slave_base)] : 1'b0;
      end
   end

   always @(negedge clk) begin
      if (bus.sclk_pos_edge && !bus.cs_n) begin
         mosi_bits.push_back(bus.mosi);
         n_rise++;
      end
      if (bus.rx_valid) rx_words.push_back(bus.rx_data);
      if (bus.tx_valid && bus.tx_ready) begin
         acc.push_back(bus.tx_data);
         acc_cs.push_back(bus.cs_n);
      end
      if (!prev_cs && bus.cs_n) begin
         cs_rises++;
         rise_at_cs = n_rise;
         neg_before = prev_neg;
      end
      prev_cs  = bus.cs_n;
      prev_neg = bus.sclk_neg_edge;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_rise = n_rise;
      b_mosi = mosi_bits.size();
      b_rx   = rx_words.size();
      b_cs   = cs_rises;
      b_acc  = acc.size();
   endtask

   task automatic arm_slave(input logic [15:0] q);
      slave_q    = q;
      slave_base = n_rise;
      slave_en   = 1'b1;
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         if (phase == p) break;
      end
   endtask

   task automatic start_frame(input logic [7:0] w, input int p);
      wait_phase(p);
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      chk("load_ready", bus.tx_ready, 1);
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_rises(input int n);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((n_rise - b_rise) >= n) break;
      end
      chk("rise_wait", ((n_rise - b_rise) >= n), 1);
   endtask

   task automatic accept_held(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.tx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Expected streams are the accepted words and slave words, MSB first
   task automatic verify(input int nf, input logic [15:0] tx16, input logic [15:0] rx16,
                         input int exp_cs, input string tag);
      logic [15:0] got;
      logic [15:0] exp;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ((cs_rises - b_cs) >= exp_cs) break;
      end
      chk({tag, "_cs_timeout"}, ((cs_rises - b_cs) >= exp_cs), 1);
      got = 16'h0000;
      for (int i = 0; i < 8 * nf; i++)
         if ((b_mosi + i) < mosi_bits.size()) got = {got[14:0], mosi_bits[b_mosi + i]};
      exp = (nf == 2) ? tx16 : {8'h00, tx16[15:8]};
      chk({tag, "_mosi"}, got, exp);
      chk({tag, "_rises"}, n_rise - b_rise, 8 * nf);
      chk({tag, "_rx_pulses"}, rx_words.size() - b_rx, nf);
      if (rx_words.size() > b_rx) chk({tag, "_rx0"}, rx_words[b_rx], rx16[15:8]);
      if (nf == 2 && rx_words.size() > b_rx + 1) chk({tag, "_rx1"}, rx_words[b_rx + 1], rx16[7:0]);
      chk({tag, "_cs_rises"}, cs_rises - b_cs, exp_cs);
      chk({tag, "_cs_after_last"}, rise_at_cs - b_rise, 8 * nf);
      chk({tag, "_cs_on_neg"}, neg_before, 1);
   endtask

   initial begin
      logic [7:0] w, m1, m2;
      bit ok;
      int bad;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;

      // reset held with random inputs
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         bus.tx_valid = 1'($urandom);
         bus.tx_data  = 8'($urandom);
         rnd_miso     = 1'($urandom);
      end
      @(negedge clk);
      chk("rst_cs_n", bus.cs_n, 1);
      chk("rst_mosi", bus.mosi, 0);
      chk("rst_tx_ready", bus.tx_ready, 1);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rx_data", bus.rx_data, 0);
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      rst_n = 1'b1;

      // 100 sclk periods idle
      bad = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         rnd_miso = 1'($urandom);
         if ({bus.cs_n, bus.mosi, bus.tx_ready, bus.rx_valid, bus.busy} !== 5'b10100) bad++;
      end
      chk("idle_stable", bad, 0);

      // single frame, load during sclk low
      snap();
      arm_slave({8'h3C, 8'h00});
      start_frame(8'hA5, 6);
      wait_rises(2);
      chk("frame_busy", bus.busy, 1);
      chk("frame_not_ready", bus.tx_ready, 0);
      verify(1, {8'hA5, 8'h00}, {8'h3C, 8'h00}, 1, "single");
      chk("post_busy", bus.busy, 0);

      // load during sclk high
      m1 = 8'($urandom);
      snap();
      arm_slave({m1, 8'h00});
      start_frame(8'hFF, 2);
      verify(1, {8'hFF, 8'h00}, {m1, 8'h00}, 1, "load_high");

      // tx_valid mid-frame is ignored, accepted once idle
      m1 = 8'($urandom);
      m2 = 8'($urandom);
      snap();
      arm_slave({m1, m2});
      start_frame(8'hA5, 6);
      wait_rises(3);
      @(posedge clk);
      #1;
      bus.tx_data  = 8'h12;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      chk("busy_reject_ready", bus.tx_ready, 0);
      accept_held(400, ok);
      bus.tx_valid = 1'b0;
      chk("busy_accept", ok, 1);
      verify(2, {8'hA5, 8'h12}, {m1, m2}, 2, "busy");
      chk("busy_handshakes", acc.size() - b_acc, 2);
      if (acc.size() > b_acc + 1) begin
         chk("busy_acc_word", acc[b_acc + 1], 8'h12);
         chk("busy_acc_cs_high", acc_cs[b_acc + 1], 1);
      end

      // reset mid-frame
      snap();
      arm_slave({8'($urandom), 8'h00});
      start_frame(8'($urandom), 6);
      wait_rises(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_cs_n", bus.cs_n, 1);
      chk("abort_mosi", bus.mosi, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_rx", rx_words.size() - b_rx, 0);
      chk("abort_rx_data", bus.rx_data, 0);
      rst_n = 1'b1;
      m1 = 8'($urandom);
      snap();
      arm_slave({m1, 8'h00});
      start_frame(8'h5A, 5);
      verify(1, {8'h5A, 8'h00}, {m1, 8'h00}, 1, "after_abort");

      // random frames at random sclk phase
      for (int k = 0; k < 6; k++) begin
         w  = 8'($urandom);
         m1 = 8'($urandom);
         snap();
         arm_slave({m1, 8'h00});
         start_frame(w, int'($urandom_range(0, 7)));
         verify(1, {w, 8'h00}, {m1, 8'h00}, 1, "random");
      end

      // two words with tx_valid held high
      m1 = 8'($urandom);
      m2 = 8'($urandom);
      snap();
      arm_slave({m1, m2});
      wait_phase(6);
      bus.tx_data  = 8'h81;
      bus.tx_valid = 1'b1;
      accept_held(20, ok);
      chk("pair_first_accept", ok, 1);
      bus.tx_data = 8'h7E;
      accept_held(400, ok);
      bus.tx_valid = 1'b0;
      chk("pair_second_accept", ok, 1);
`ifdef SPI_SHIFT_BURST_EN
      verify(2, {8'h81, 8'h7E}, {m1, m2}, 1, "burst");
`else
      verify(2, {8'h81, 8'h7E}, {m1, m2}, 2, "noburst");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
